// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-to-1 valid/ready stream mux (round-robin or fixed priority, optional forced select) with a registered output
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   in_valid / in_ready   per-channel handshake; in_ready is one-hot or zero
//   data_bus              channel i at [i*DATA_BITS +: DATA_BITS]
//   force_en / force_sel  restrict arbitration to a single channel
//   out_valid / out_ready registered output handshake
//   out_data / out_sel    registered data and the index of the channel that supplied it
module rr_stream_mux #(
  parameter int SELECT_BIT = 2,
  parameter int DATA_BITS = 8,
  parameter bit RR_MODE = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [(1<<SELECT_BIT)-1:0]            in_valid,
  output logic [(1<<SELECT_BIT)-1:0]            in_ready,
  input  logic [(1<<SELECT_BIT)*DATA_BITS-1:0]  data_bus,
  input  logic                                  force_en,
  input  logic [SELECT_BIT-1:0]                 force_sel,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [DATA_BITS-1:0]                  out_data,
  output logic [SELECT_BIT-1:0]                 out_sel
);
  localparam int N = 1 << SELECT_BIT;
  logic [N-1:0] elig;
  logic [SELECT_BIT-1:0] base, win;
  logic load_en, take;
  logic out_valid_q, out_valid_d;
  logic [DATA_BITS-1:0] out_data_q, out_data_d;
  logic [SELECT_BIT-1:0] out_sel_q, out_sel_d, ptr_q, ptr_d;
  // Winner scan walks from the highest offset down so the last hit is the first eligible channel after base.
  always_comb begin
    elig = force_en ? in_valid & (N'(1) << force_sel) : in_valid;
    base = RR_MODE ? ptr_q : '0;
    win = '0;
    for (int k = N - 1; k >= 0; k--) win = elig[base + SELECT_BIT'(k)] ? base + SELECT_BIT'(k) : win;
    load_en = !out_valid_q || out_ready;
    take = load_en && |elig && !reset;
    in_ready = take ? N'(1) << win : '0;
    out_valid_d = load_en ? |elig : out_valid_q;
    out_data_d = take ? data_bus[win*DATA_BITS +: DATA_BITS] : out_data_q;
    out_sel_d = take ? win : out_sel_q;
    ptr_d = (take && RR_MODE) ? win + SELECT_BIT'(1) : ptr_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_sel_q <= '0;
      ptr_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_sel_q <= out_sel_d;
      ptr_q <= ptr_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_sel = out_sel_q;
endmodule
